// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: wb_sel codes, load funct3 encodings and FSM states.
package wb_pkg;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational load extraction: lane select, sign/zero extension, misaligned/illegal flag.
module load_extract
    import wb_pkg::*;
#(
    parameter  int unsigned DATAW = 32,
    localparam int unsigned OFFW  = $clog2(DATAW / 8)
) (
    input  logic [DATAW-1:0] i_raw,
    input  logic [2:0]       i_funct3,
    input  logic [OFFW-1:0]  i_off,
    output logic [DATAW-1:0] o_data_c,
    output logic             o_bad_c
);

    logic [DATAW-1:0] w_sh;

    // Bring the addressed lane down to bit 0.
    assign w_sh = i_raw >> {i_off, 3'b000};

    always_comb begin
        o_data_c = '0;
        o_bad_c  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data_c = DATAW'($signed(w_sh[7:0]));
            F3_LBU: o_data_c = DATAW'(w_sh[7:0]);
            F3_LH: begin
                o_data_c = DATAW'($signed(w_sh[15:0]));
                o_bad_c  = i_off[0];
            end
            F3_LHU: begin
                o_data_c = DATAW'(w_sh[15:0]);
                o_bad_c  = i_off[0];
            end
            F3_LW: begin
                o_data_c = DATAW'($signed(w_sh[31:0]));
                o_bad_c  = (i_off[1:0] != 2'b00);
            end
            F3_LWU: begin
                o_data_c = DATAW'(w_sh[31:0]);
                o_bad_c  = (DATAW != 64) || (i_off[1:0] != 2'b00);
            end
            F3_LD: begin
                o_data_c = w_sh;
                o_bad_c  = (DATAW != 64) || (i_off != '0);
            end
            default: o_bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage with load extraction and memory-response wait/timeout.
// Optional WB_CSR_EN: adds csr_rdata, written for wb_sel=3 (otherwise zero is written).
module wb_stage
    import wb_pkg::*;
#(
    parameter  int unsigned DATAW       = 32,
    parameter  int unsigned REGW        = 5,
    parameter  int unsigned MEM_TIMEOUT = 15,
    localparam int unsigned OFFW        = $clog2(DATAW / 8),
    localparam int unsigned CNTW        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] alu,
    input  logic [DATAW-1:0] pc4,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       funct3,
    input  logic [OFFW-1:0]  byte_off,
    input  logic [REGW-1:0]  rd_addr,
    input  logic             rd_we,
    input  logic             mem_rsp_valid,
    input  logic [DATAW-1:0] mem_rsp_data,
`ifdef WB_CSR_EN
    input  logic [DATAW-1:0] csr_rdata,
`endif
    output logic             rf_we,
    output logic [REGW-1:0]  rf_waddr,
    output logic [DATAW-1:0] rf_wdata,
    output logic             err
);

    wb_state_e        r_state, w_state_nxt;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic [REGW-1:0]  r_rd_addr, w_rd_addr_nxt;
    logic             r_rd_we, w_rd_we_nxt;
    logic [2:0]       r_funct3, w_funct3_nxt;
    logic [OFFW-1:0]  r_byte_off, w_byte_off_nxt;
    logic             w_rf_we_nxt;
    logic [REGW-1:0]  w_rf_waddr_nxt;
    logic [DATAW-1:0] w_rf_wdata_nxt;
    logic             w_err_nxt;

    logic             w_accept;
    logic [2:0]       w_x_funct3;
    logic [OFFW-1:0]  w_x_off;
    logic [DATAW-1:0] w_ld_data;
    logic             w_ld_bad;
    logic [DATAW-1:0] w_csr_val;
    logic [REGW-1:0]  w_cmp_rd;
    logic             w_cmp_we;

`ifdef WB_CSR_EN
    assign w_csr_val = csr_rdata;
`else
    assign w_csr_val = '0;
`endif

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // In WAIT the load shape comes from the latched op, otherwise from the live inputs.
    assign w_x_funct3 = (r_state == WAIT) ? r_funct3   : funct3;
    assign w_x_off    = (r_state == WAIT) ? r_byte_off : byte_off;
    assign w_cmp_rd   = (r_state == WAIT) ? r_rd_addr  : rd_addr;
    assign w_cmp_we   = (r_state == WAIT) ? r_rd_we    : rd_we;

    load_extract #(.DATAW(DATAW)) u_load_extract (
        .i_raw    (mem_rsp_data),
        .i_funct3 (w_x_funct3),
        .i_off    (w_x_off),
        .o_data_c (w_ld_data),
        .o_bad_c  (w_ld_bad)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rd_addr_nxt  = r_rd_addr;
        w_rd_we_nxt    = r_rd_we;
        w_funct3_nxt   = r_funct3;
        w_byte_off_nxt = r_byte_off;
        w_rf_we_nxt    = 1'b0;
        w_rf_waddr_nxt = rf_waddr;
        w_rf_wdata_nxt = rf_wdata;
        w_err_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (wb_sel != WB_MEM) begin
                        w_rf_we_nxt    = rd_we && (rd_addr != '0);
                        w_rf_waddr_nxt = rd_addr;
                        case (wb_sel)
                            WB_ALU:  w_rf_wdata_nxt = alu;
                            WB_PC4:  w_rf_wdata_nxt = pc4;
                            default: w_rf_wdata_nxt = w_csr_val;
                        endcase
                    end else if (!mem_rsp_valid) begin
                        w_state_nxt    = WAIT;
                        w_cnt_nxt      = '0;
                        w_rd_addr_nxt  = rd_addr;
                        w_rd_we_nxt    = rd_we;
                        w_funct3_nxt   = funct3;
                        w_byte_off_nxt = byte_off;
                    end else if (w_ld_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_rf_we_nxt    = w_cmp_we && (w_cmp_rd != '0);
                        w_rf_waddr_nxt = w_cmp_rd;
                        w_rf_wdata_nxt = w_ld_data;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + CNTW'(1);
                if (mem_rsp_valid) begin
                    w_state_nxt = IDLE;
                    if (w_ld_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_rf_we_nxt    = w_cmp_we && (w_cmp_rd != '0);
                        w_rf_waddr_nxt = w_cmp_rd;
                        w_rf_wdata_nxt = w_ld_data;
                    end
                end else if (r_cnt == CNTW'(MEM_TIMEOUT - 1)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
            r_funct3   <= '0;
            r_byte_off <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_we    <= w_rd_we_nxt;
            r_funct3   <= w_funct3_nxt;
            r_byte_off <= w_byte_off_nxt;
            rf_we      <= w_rf_we_nxt;
            rf_waddr   <= w_rf_waddr_nxt;
            rf_wdata   <= w_rf_wdata_nxt;
            err        <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage (DATAW=32, MEM_TIMEOUT=4).
module tb_wb_stage;

    localparam int unsigned DATAW = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned NVEC  = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DATAW-1:0] alu = '0;
    logic [DATAW-1:0] pc4 = '0;
    logic [1:0]       wb_sel = '0;
    logic [2:0]       funct3 = '0;
    logic [1:0]       byte_off = '0;
    logic [REGW-1:0]  rd_addr = '0;
    logic             rd_we = 1'b0;
    logic             mem_rsp_valid = 1'b0;
    logic [DATAW-1:0] mem_rsp_data = '0;
`ifdef WB_CSR_EN
    logic [DATAW-1:0] csr_rdata = 32'h0000_1234;
`endif
    logic             rf_we;
    logic [REGW-1:0]  rf_waddr;
    logic [DATAW-1:0] rf_wdata;
    logic             err;

    int n_vec = 0;
    int n_bad = 0;

    wb_stage #(.DATAW(DATAW), .REGW(REGW), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu           (alu),
        .pc4           (pc4),
        .wb_sel        (wb_sel),
        .funct3        (funct3),
        .byte_off      (byte_off),
        .rd_addr       (rd_addr),
        .rd_we         (rd_we),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
`ifdef WB_CSR_EN
        .csr_rdata     (csr_rdata),
`endif
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] csr_exp;
`ifdef WB_CSR_EN
        csr_exp = 32'h0000_1234;
`else
        csr_exp = 32'h0;
`endif
        //          sel   f3      off    rd   we   alu            pc4           we   err  data
        vecs[0]  = '{2'd1, 3'b000, 2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{2'd2, 3'b000, 2'd0, 5'd0, 1'b1, 32'h0,        32'h00000104, 1'b0, 1'b0, 32'h00000104};
        vecs[2]  = '{2'd0, 3'b000, 2'd2, 5'd1, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[3]  = '{2'd0, 3'b100, 2'd3, 5'd2, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00000080};
        vecs[4]  = '{2'd0, 3'b001, 2'd2, 5'd3, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'hFFFF80FF};
        vecs[5]  = '{2'd0, 3'b101, 2'd0, 5'd4, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00007F01};
        vecs[6]  = '{2'd0, 3'b010, 2'd0, 5'd6, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'h80FF7F01};
        vecs[7]  = '{2'd0, 3'b000, 2'd1, 5'd7, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0000007F};
        vecs[8]  = '{2'd3, 3'b000, 2'd0, 5'd8, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b0, csr_exp};
        vecs[9]  = '{2'd0, 3'b010, 2'd1, 5'd9, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
        vecs[10] = '{2'd0, 3'b011, 2'd0, 5'd9, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
        vecs[11] = '{2'd0, 3'b110, 2'd0, 5'd9, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
        vecs[12] = '{2'd0, 3'b001, 2'd1, 5'd9, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
        vecs[13] = '{2'd1, 3'b000, 2'd0, 5'd10, 1'b0, 32'h00000055, 32'h0,       1'b0, 1'b0, 32'h00000055};

        // Reset state
        #12;
        check("rst_rf_we", 32'(rf_we), 32'h0);
        check("rst_waddr", 32'(rf_waddr), 32'h0);
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        tick();

        // Back-to-back single-cycle ops with same-cycle memory response
        mem_rsp_data = 32'h80FF7F01;
        for (int i = 0; i < int'(NVEC); i++) begin
            wb_sel = vecs[i].sel; funct3 = vecs[i].f3; byte_off = vecs[i].off;
            rd_addr = vecs[i].rd; rd_we = vecs[i].we; alu = vecs[i].alu; pc4 = vecs[i].pc4;
            in_valid = 1'b1; mem_rsp_valid = 1'b1;
            tick();
            check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].exp_err) check($sformatf("v%0d_data", i), rf_wdata, vecs[i].exp_data);
            if (vecs[i].exp_we) check($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].rd));
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        check("idle_we", 32'(rf_we), 32'h0);
        check("idle_hold", rf_wdata, 32'h00000055);

        // Response with no op in IDLE is ignored
        mem_rsp_valid = 1'b1;
        tick();
        check("stray_rsp_we", 32'(rf_we), 32'h0);
        check("stray_rsp_err", 32'(err), 32'h0);

        // Wait path: response three cycles after accept
        mem_rsp_valid = 1'b0; wb_sel = 2'd0; funct3 = 3'b010; byte_off = 2'd0;
        rd_addr = 5'd11; rd_we = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; funct3 = 3'b000; byte_off = 2'd3; rd_addr = 5'd0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("wait%0d_ready", c), 32'(in_ready), 32'h0);
            check($sformatf("wait%0d_we", c), 32'(rf_we), 32'h0);
            if (c == 3) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        check("wait_we", 32'(rf_we), 32'h1);
        check("wait_waddr", 32'(rf_waddr), 32'd11);
        check("wait_data", rf_wdata, 32'h12345678);
        check("wait_ready", 32'(in_ready), 32'h1);
        tick();
        check("wait_we_drop", 32'(rf_we), 32'h0);

        // Timeout: no response for MEM_TIMEOUT cycles
        rd_addr = 5'd12; funct3 = 3'b010; byte_off = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("to%0d_err", c), 32'(err), 32'h0);
            check($sformatf("to%0d_ready", c), 32'(in_ready), 32'h0);
            tick();
        end
        check("to_err", 32'(err), 32'h1);
        check("to_we", 32'(rf_we), 32'h0);
        check("to_ready", 32'(in_ready), 32'h1);
        tick();
        check("to_err_drop", 32'(err), 32'h0);

        // Response on the timeout cycle wins
        rd_addr = 5'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
        tick();
        mem_rsp_valid = 1'b0;
        check("tow_we", 32'(rf_we), 32'h1);
        check("tow_err", 32'(err), 32'h0);
        check("tow_data", rf_wdata, 32'hCAFEF00D);
        check("tow_waddr", 32'(rf_waddr), 32'd13);

        // Reset mid-WAIT aborts silently
        rd_addr = 5'd14; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        check("rstw_ready", 32'(in_ready), 32'h1);
        check("rstw_we", 32'(rf_we), 32'h0);
        check("rstw_err", 32'(err), 32'h0);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("rstw_post_we", 32'(rf_we), 32'h0);
        check("rstw_post_err", 32'(err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
